// File: rtl/enc_pkg.sv
// Shared state encoding and default widths for the sequential priority encoder.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam int ENC_N_IN  = 8;
    localparam int ENC_OUT_W = 3;

endpackage

// File: rtl/encoder_8_3_seq_prio_find.sv
// Purpose: combinational search for the highest-priority set bit of a pending vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
module prio_find #(
    parameter int N_IN       = 8,
    parameter int OUT_W      = 3,
    parameter int HIGH_FIRST = 1
) (
    input  logic [N_IN-1:0]  i_pend,
    output logic [OUT_W-1:0] o_idx,
    output logic             o_any
);

    // Later loop iterations overwrite earlier ones, so the loop runs from
    // lowest to highest priority and the winner is the last hit.
    always_comb begin
        o_idx = '0;
        o_any = |i_pend;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < N_IN; i++) begin
                if (i_pend[i]) o_idx = OUT_W'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (i_pend[i]) o_idx = OUT_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_seq.sv
// Purpose: captures a request vector on E and emits the index of each set bit, priority order.
// Latency: load edge -> first valid index next cycle; one Done cycle after the last accept.
// Backpressure: Out/V held stable while Rdy=0. Optional Cnt popcount port under ENC_COUNT_EN.
module encoder_8_3_seq
    import enc_pkg::*;
#(
    parameter int N_IN       = ENC_N_IN,
    parameter int OUT_W      = ENC_OUT_W,
    parameter int HIGH_FIRST = 1
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             E,
    input  logic [N_IN-1:0]  In,
    input  logic             Rdy,
    output logic [OUT_W-1:0] Out,
    output logic             V,
    output logic             Busy,
    output logic             Done
`ifdef ENC_COUNT_EN
    ,
    output logic [OUT_W:0]   Cnt
`endif
);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [N_IN-1:0]  r_pend;
    logic [N_IN-1:0]  w_pend_nxt;
    logic [N_IN-1:0]  w_onehot;
    logic [N_IN-1:0]  w_pend_clr;
    logic [OUT_W-1:0] w_idx;
    logic             w_any;

    prio_find #(
        .N_IN       (N_IN),
        .OUT_W      (OUT_W),
        .HIGH_FIRST (HIGH_FIRST)
    ) u_prio_find (
        .i_pend (r_pend),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_onehot   = N_IN'(1) << w_idx;
    assign w_pend_clr = r_pend & ~w_onehot;

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        case (r_state)
            IDLE: begin
                if (E) begin
                    if (|In) begin
                        w_pend_nxt  = In;
                        w_state_nxt = SCAN;
                    end else begin
                        // Empty vector still reports completion.
                        w_state_nxt = DONE;
                    end
                end
            end
            SCAN: begin
                if (Rdy) begin
                    w_pend_nxt = w_pend_clr;
                    if (w_pend_clr == '0) w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign V    = (r_state == SCAN) && w_any;
    assign Out  = V ? w_idx : '0;
    assign Busy = (r_state != IDLE);
    assign Done = (r_state == DONE);

`ifdef ENC_COUNT_EN
    logic [OUT_W:0] r_cnt;
    logic [OUT_W:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_popcnt = w_popcnt + {{OUT_W{1'b0}}, In[i]};
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && E) begin
            r_cnt <= w_popcnt;
        end
    end

    assign Cnt = r_cnt;
`endif

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Bench for encoder_8_3_seq: directed loads; expected index/Done events queued and
// compared by a negedge monitor. Two instances cover HIGH_FIRST=1 and HIGH_FIRST=0.
module tb_encoder_8_3_seq;

    logic       clka = 1'b0;
    logic       rst;
    logic       E, E2;
    logic [7:0] In, In2;
    logic       Rdy, Rdy2;
    logic [2:0] Out, Out2;
    logic       V, V2, Busy, Busy2, Done, Done2;
`ifdef ENC_COUNT_EN
    logic [3:0] Cnt, Cnt2;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int q1[$];
    int q2[$];
    int vc, dc, nc;

    always #10 clka = ~clka;

    encoder_8_3_seq #(.HIGH_FIRST(1)) dut (
        .clka (clka), .rst (rst), .E (E), .In (In), .Rdy (Rdy),
        .Out (Out), .V (V), .Busy (Busy), .Done (Done)
`ifdef ENC_COUNT_EN
        , .Cnt (Cnt)
`endif
    );

    encoder_8_3_seq #(.HIGH_FIRST(0)) dut_lf (
        .clka (clka), .rst (rst), .E (E2), .In (In2), .Rdy (Rdy2),
        .Out (Out2), .V (V2), .Busy (Busy2), .Done (Done2)
`ifdef ENC_COUNT_EN
        , .Cnt (Cnt2)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Event code: 0..7 = accepted index, 8 = Done pulse.
    task automatic sb_event(input bit sel, input int act);
        int e;
        if ((sel ? q2.size() : q1.size()) == 0) begin
            n_checks++;
            $display("FAIL sb%0d: got event %0d, expected none", sel, act);
        end else begin
            e = sel ? q2.pop_front() : q1.pop_front();
            chk(sel ? "sb_lf" : "sb_hf", act, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clka);
            if (rst === 1'b0) begin
                if (V === 1'b1 && Rdy === 1'b1)   sb_event(1'b0, int'(Out));
                if (Done === 1'b1)                sb_event(1'b0, 8);
                if (V2 === 1'b1 && Rdy2 === 1'b1) sb_event(1'b1, int'(Out2));
                if (Done2 === 1'b1)               sb_event(1'b1, 8);
            end
        end
    end

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    function automatic bit s_busy(input bit sel); return sel ? Busy2 : Busy; endfunction
    function automatic bit s_v(input bit sel);    return sel ? V2 : V;       endfunction
    function automatic bit s_done(input bit sel); return sel ? Done2 : Done; endfunction

    // Steps until the instance returns to IDLE, counting busy/valid/done cycles.
    task automatic run(input bit sel, output int o_vc, output int o_dc, output int o_nc);
        o_vc = 0; o_dc = 0; o_nc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!s_busy(sel)) break;
            o_nc++;
            if (s_v(sel))    o_vc++;
            if (s_done(sel)) o_dc++;
            cyc();
        end
        chk("run_idle", int'(s_busy(sel)), 0);
    endtask

    task automatic push1(input int a[]);
        foreach (a[i]) q1.push_back(a[i]);
    endtask

    initial begin
        rst = 1'b1; E = 1'b1; In = 8'hFF; Rdy = 1'b1;
        E2 = 1'b0; In2 = 8'h00; Rdy2 = 1'b1;

        // Reset with a load request present.
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("rst_out", int'(Out), 0);
        chk("rst_v", int'(V), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        rst = 1'b0; E = 1'b0; In = 8'h00;
        cyc();

        // Full scan, high-first.
        E = 1'b1; In = 8'b1010_0101; push1('{7, 5, 2, 0, 8});
        cyc(); E = 1'b0;
`ifdef ENC_COUNT_EN
        chk("cnt_a5", int'(Cnt), 4);
`endif
        run(1'b0, vc, dc, nc);
        chk("full_vcyc", vc, 4); chk("full_done", dc, 1); chk("full_len", nc, 5);

        // Back-pressure.
        E = 1'b1; In = 8'h81; Rdy = 1'b0; push1('{7, 0, 8});
        cyc(); E = 1'b0;
`ifdef ENC_COUNT_EN
        chk("cnt_81", int'(Cnt), 2);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("hold_out", int'(Out), 7);
            chk("hold_v", int'(V), 1);
            cyc();
        end
        Rdy = 1'b1;
        run(1'b0, vc, dc, nc);
        chk("bp_vcyc", vc, 2); chk("bp_done", dc, 1); chk("bp_len", nc, 3);

        // Empty vector.
        E = 1'b1; In = 8'h00; push1('{8});
        cyc(); E = 1'b0;
        chk("empty_out", int'(Out), 0);
        run(1'b0, vc, dc, nc);
        chk("empty_vcyc", vc, 0); chk("empty_done", dc, 1); chk("empty_len", nc, 1);

        // Load attempt while busy must not disturb the scan.
        E = 1'b1; In = 8'b1010_0101; push1('{7, 5, 2, 0, 8});
        cyc(); In = 8'hFF;
        cyc(); cyc(); E = 1'b0; In = 8'h00;
        run(1'b0, vc, dc, nc);
        chk("busy_vcyc", vc, 2); chk("busy_done", dc, 1); chk("busy_len", nc, 3);

        // Reset mid-scan after the first index.
        E = 1'b1; In = 8'b1010_0101; push1('{7});
        cyc(); E = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_v", int'(V), 0);
        chk("mid_rst_busy", int'(Busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_nodone", int'(Done), 0);
            cyc();
        end

`ifdef ENC_COUNT_EN
        E = 1'b1; In = 8'hF0; push1('{7, 6, 5, 4, 8});
        cyc(); E = 1'b0;
        chk("cnt_f0", int'(Cnt), 4);
        run(1'b0, vc, dc, nc);
`endif

        // Low-first priority on the second instance.
        E2 = 1'b1; In2 = 8'b1000_0010;
        q2.push_back(1); q2.push_back(7); q2.push_back(8);
        cyc(); E2 = 1'b0;
        chk("lf_first", int'(Out2), 1);
        run(1'b1, vc, dc, nc);
        chk("lf_vcyc", vc, 2); chk("lf_done", dc, 1); chk("lf_len", nc, 3);

        @(negedge clka);
        chk("q_hf_drained", q1.size(), 0);
        chk("q_lf_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
